// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares one pipelined memory read port between the instruction-fetch
//   requester and the data-load requester. It issues at most one read per
//   cycle. A LATENCY-deep tag pipeline follows each in-flight read so that
//   the returning doubleword goes to the requester that issued it. A fetch
//   flush discards stale fetch responses.
//
//   Build option: MEM_ARB_ROUND_ROBIN_EN
//     defined   - contention goes to the requester not granted most recently
//                 (fetch wins the first tie after reset)
//     undefined - fixed priority, load always beats fetch
//
//   Parameter:
//     LATENCY        memory read latency in cycles, legal 1..8
//   Ports:
//     clk, rst_n     core clock; synchronous active-low reset
//     fetchReq/Addr  fetch read request and doubleword address
//     fetchFlush     discard every in-flight fetch read, including one
//                    granted this cycle
//     fetchGnt       fetch request accepted this cycle
//     fetchRspValid/Data  fetch response
//     loadReq/Addr   load read request and doubleword address
//     loadGnt        load request accepted this cycle
//     loadRspValid/Data   load response
//     memReqValid    read issued to memory this cycle
//     memAddr        address of the issued read (zero when idle)
//     memRspData     memory data, valid LATENCY cycles after issue
module mem_read_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetchReq,
  input  logic [0:60]  fetchAddr,
  input  logic         fetchFlush,
  output logic         fetchGnt,
  output logic         fetchRspValid,
  output logic [0:63]  fetchRspData,
  input  logic         loadReq,
  input  logic [0:60]  loadAddr,
  output logic         loadGnt,
  output logic         loadRspValid,
  output logic [0:63]  loadRspData,
  output logic         memReqValid,
  output logic [0:60]  memAddr,
  input  logic [0:63]  memRspData
);

  // Tag pipeline: stage 0 holds reads issued last cycle. The last stage
  // lines up with memRspData.
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] is_load_q, is_load_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to load. Reset leaves it set, so
  // fetch wins the first tie.
  logic last_gnt_load_q, last_gnt_load_d;
`endif

  // Grant decision. The whole block is muted while reset is asserted.
  always_comb begin
    fetchGnt = 1'b0;
    loadGnt  = 1'b0;
    if (rst_n) begin
      if (fetchReq && loadReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        fetchGnt = last_gnt_load_q;
        loadGnt  = ~last_gnt_load_q;
`else
        loadGnt  = 1'b1;
`endif
      end else begin
        fetchGnt = fetchReq;
        loadGnt  = loadReq;
      end
    end
  end

  assign memReqValid = fetchGnt | loadGnt;

  always_comb begin
    memAddr = '0;
    if (loadGnt) begin
      memAddr = loadAddr;
    end else if (fetchGnt) begin
      memAddr = fetchAddr;
    end
  end

  // Tag shift. A flush kills fetch tags as they advance, and it also kills a
  // fetch grant entering stage 0. The fetchGnt output itself is untouched,
  // because the requester has already handed off its address.
  always_comb begin
    valid_d      = '0;
    is_load_d    = '0;
    valid_d[0]   = memReqValid & ~(fetchFlush & ~loadGnt);
    is_load_d[0] = loadGnt;
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k]   = valid_q[k-1] & ~(fetchFlush & ~is_load_q[k-1]);
      is_load_d[k] = is_load_q[k-1];
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_gnt_load_d = last_gnt_load_q;
    if (loadGnt) begin
      last_gnt_load_d = 1'b1;
    end else if (fetchGnt) begin
      last_gnt_load_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      is_load_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_load_q <= 1'b1;
`endif
    end else begin
      valid_q   <= valid_d;
      is_load_q <= is_load_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_load_q <= last_gnt_load_d;
`endif
    end
  end

  // The response valids are gated by rst_n. In the first reset cycle the
  // stages still hold pre-reset tags, and those must not leak out.
  // A fetch response that emerges during a flush is suppressed here.
  // Load responses are never affected by a flush.
  assign loadRspValid  = rst_n & valid_q[LATENCY-1] & is_load_q[LATENCY-1];
  assign fetchRspValid = rst_n & valid_q[LATENCY-1] & ~is_load_q[LATENCY-1]
                         & ~fetchFlush;

  assign fetchRspData = memRspData;
  assign loadRspData  = memRspData;

endmodule
